// File: rtl/seg7_pkg.sv
// Shared glyph table and width helper for the seg7 scanning display driver.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segment patterns g..a for hex digits 0..F.
    localparam logic [6:0] GLYPH [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = GLYPH[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver with guard interval per slot.
// Define SEG7_SCAN_LZB_EN to enable leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 50000,
    parameter int GUARD  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an
);

    localparam int IW = (DIGITS > 1) ? clog2(DIGITS) : 1;
    localparam int TW = clog2(DWELL);

    logic [TW-1:0]         tick;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   val;
    logic [DIGITS-1:0]     dpr;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [DIGITS-1:0]     an_next;
    logic [6:0]            glyph;
    logic                  in_guard;

    assign in_guard = (int'(tick) < GUARD);

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        an_next = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib    = val[4*k +: 4];
                cur_dp     = dpr[k];
                an_next[k] = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .nibble (cur_nib),
        .glyph  (glyph)
    );

`ifdef SEG7_SCAN_LZB_EN
    // Flags are derived from the incoming word so they land together with val.
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    logic [DIGITS-1:0] blank;
    logic [DIGITS-1:0] blank_next;
    logic              zero_above;

    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above    = zero_above && (data[4*k +: 4] == 4'h0);
            blank_next[k] = zero_above && (k > 0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       blank <= BLANK_RST;
        else if (load) blank <= blank_next;
    end

    always_comb begin
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) cur_blank = blank[k];
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= '0;
            idx  <= '0;
            val  <= '0;
            dpr  <= '0;
        end else begin
            if (load) begin
                val <= data;
                dpr <= dp;
            end
            if (tick == TW'(DWELL - 1)) begin
                tick <= '0;
                if (idx == IW'(DIGITS - 1)) idx <= '0;
                else                        idx <= idx + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

    // Outputs lag the scan state by one cycle; enable only masks, never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            an   <= '1;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else if (!enable || in_guard) begin
            an   <= '1;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_next;
            seg  <= cur_blank ? SEG_OFF : glyph;
            dp_n <= ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized scoreboard bench for seg7_scan (DIGITS=4, DWELL=8, GUARD=2).
module tb_seg7_scan;

    localparam int DIGITS = 4;
    localparam int DWELL  = 8;
    localparam int GUARD  = 2;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] ref_glyph [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan #(
        .DIGITS (DIGITS),
        .DWELL  (DWELL),
        .GUARD  (GUARD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .load   (load),
        .data   (data),
        .dp     (dp),
        .seg    (seg),
        .dp_n   (dp_n),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: cycles since reset give slot position directly.
    int          mc = 0;
    logic [15:0] mval = '0;
    logic [3:0]  mdp = '0;
    bit          started = 0;

    function automatic int model_idx();
        return (mc / DWELL) % DIGITS;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int t, i, nib;
        bit blanked;
        if (started || rst) begin
            if (rst) begin
                e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1;
            end else begin
                t = mc % DWELL;
                i = model_idx();
                if (!enable || t < GUARD) begin
                    e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1;
                end else begin
                    nib = int'((mval >> (4 * i)) & 16'hF);
                    blanked = 0;
`ifdef SEG7_SCAN_LZB_EN
                    blanked = (i > 0) && ((mval >> (4 * i)) == 16'h0);
`endif
                    e.an   = ~(4'b0001 << i);
                    e.seg  = blanked ? 7'h7F : ref_glyph[nib];
                    e.dp_n = ~mdp[i];
                end
            end
            exp_q.push_back(e);
            if (rst) begin
                mc = 0; mval = '0; mdp = '0; started = 1;
            end else begin
                mc++;
                if (load) begin
                    mval = data; mdp = dp;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [6:0] act, input logic [6:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("an",   {3'b0, an},   {3'b0, e.an});
            check_output("seg",  seg,          e.seg);
            check_output("dp_n", {6'b0, dp_n}, {6'b0, e.dp_n});
        end
    end

    task automatic apply_stimulus(input logic r, input logic e, input logic l,
                                  input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        rst = r; enable = e; load = l; data = d; dp = p;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, enable, 1'b0, data, dp);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        apply_stimulus(1'b0, enable, 1'b1, d, p);
        apply_stimulus(1'b0, enable, 1'b0, d, p);
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; load = 1'b0; data = '0; dp = '0;
        $display("[TB] reset release");
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(40);

        $display("[TB] hex decode");
        do_load(16'hCAFE, 4'b0010);
        idle(40);

        $display("[TB] enable gating");
        apply_stimulus(1'b0, 1'b0, 1'b0, data, dp);
        idle(19);
        apply_stimulus(1'b0, 1'b1, 1'b0, data, dp);
        idle(40);

        $display("[TB] load mid-slot");
        do_load(16'h0001, 4'b0000);
        n = 0;
        while (!(model_idx() == 0 && (mc % DWELL) == 3) && n < 64) begin
            idle(1); n++;
        end
        do_load(16'h0009, 4'b0001);
        idle(36);

        $display("[TB] leading zero patterns");
        do_load(16'h0040, 4'b0000);
        idle(36);
        do_load(16'h0000, 4'b1000);
        idle(36);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 600; k++) begin
            logic r, e, l;
            logic [15:0] d;
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 15) == 0) ? ~enable : enable;
            l = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            apply_stimulus(r, e, l, d, 4'($urandom));
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, data, dp);
        idle(8);

        $display("[TB] reset mid-frame");
        do_load(16'h5A3C, 4'b1111);
        n = 0;
        while (!(model_idx() == 2 && (mc % DWELL) == 4) && n < 64) begin
            idle(1); n++;
        end
        n_checks++;
        if (n >= 64) begin
            n_fail++;
            $display("[TB] FAIL reset_wait: idx 2 not reached within %0d cycles", n);
        end
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF);
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'hFFFF, 4'hF);
        idle(40);

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
